// File: rtl/seq_detect_param_if.sv
// Symbol stream, pattern configuration and detector status bundle for seq_detect_param.
interface seq_detect_param_if #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8,
   parameter int IDXW  = $clog2(DEPTH + 1)
) ();

   logic             en;
   logic             in_valid;
   logic [WIDTH-1:0] in_sym;
   logic             cfg_we;
   logic [IDXW-1:0]  cfg_idx;
   logic [WIDTH-1:0] cfg_sym;
   logic             cfg_len_we;
   logic [IDXW-1:0]  cfg_len;
   logic             cnt_clr;

   logic             first_hit;
   logic             armed;
   logic [IDXW-1:0]  progress;
   logic             match;
   logic             timeout;
   logic [CNT_W-1:0] match_count;

   modport master (
      output en, in_valid, in_sym,
      output cfg_we, cfg_idx, cfg_sym, cfg_len_we, cfg_len, cnt_clr,
      input  first_hit, armed, progress, match, timeout, match_count
   );

   modport slave (
      input  en, in_valid, in_sym,
      input  cfg_we, cfg_idx, cfg_sym, cfg_len_we, cfg_len, cnt_clr,
      output first_hit, armed, progress, match, timeout, match_count
   );

endinterface

// File: rtl/seq_detect_param.sv
// Programmable sequence detector: matches a run-time pattern of 1..DEPTH symbols
// on a qualified symbol stream, with optional inter-symbol gap timeout and a
// saturating match counter.
//
// idx (progress) | meaning
// 0              | idle, waiting for pat[0]
// 1..len-1       | armed, that many pattern symbols matched so far
module seq_detect_param #(
   parameter int WIDTH   = 2,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 8,
   parameter int MAX_GAP = 0
) (
   input  logic              clk,
   input  logic              rst,
   seq_detect_param_if.slave bus
);

   localparam int IDXW = $clog2(DEPTH + 1);
   localparam int GAPW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
   localparam bit GAP_EN = (MAX_GAP > 0);
   localparam logic [GAPW-1:0] GAP_LAST = GAPW'((MAX_GAP > 0) ? MAX_GAP - 1 : 0);
   localparam logic [IDXW-1:0] LEN_MAX  = IDXW'(DEPTH);
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

   logic [WIDTH-1:0] pat_q [DEPTH];
   logic [WIDTH-1:0] pat_d [DEPTH];
   logic [IDXW-1:0]  len_q, len_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [GAPW-1:0]  gap_q, gap_d;
   logic             match_q, match_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [WIDTH-1:0] cur_pat;
   logic [IDXW-1:0]  idx_inc;
   logic             cfg_wr;
   logic             sym_step;
   logic             idle_step;
   logic             sym_hit;
   logic             first_sym;
   logic             last_sym;

   // Select the pattern symbol expected at the current position.
   always_comb begin
      cur_pat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (idx_q == IDXW'(i)) cur_pat = pat_q[i];
      end
   end

   // A config write aborts any partial match and swallows the symbol of that cycle.
   assign cfg_wr    = bus.cfg_we | bus.cfg_len_we;
   assign sym_step  = bus.en & bus.in_valid & ~cfg_wr;
   assign idle_step = GAP_EN & bus.en & ~bus.in_valid & ~cfg_wr & (idx_q != '0);
   assign idx_inc   = idx_q + IDX_ONE;
   assign sym_hit   = (bus.in_sym == cur_pat);
   assign first_sym = (bus.in_sym == pat_q[0]);
   assign last_sym  = (idx_inc == len_q);

   // Pattern slot and length registers; out-of-range slots are ignored, length is clamped to 1..DEPTH.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         pat_d[i] = pat_q[i];
         if (bus.cfg_we && (bus.cfg_idx == IDXW'(i))) pat_d[i] = bus.cfg_sym;
      end
      len_d = len_q;
      if (bus.cfg_len_we) begin
         if (bus.cfg_len == '0)          len_d = IDX_ONE;
         else if (bus.cfg_len > LEN_MAX) len_d = LEN_MAX;
         else                            len_d = bus.cfg_len;
      end
   end

   // Match progress, gap timer and the match/timeout pulses.
   always_comb begin
      idx_d     = idx_q;
      gap_d     = gap_q;
      match_d   = 1'b0;
      timeout_d = 1'b0;
      if (cfg_wr) begin
         idx_d = '0;
         gap_d = '0;
      end else if (sym_step) begin
         gap_d = '0;
         if (sym_hit) begin
            if (last_sym) begin
               idx_d   = '0;
               match_d = 1'b1;
            end else begin
               idx_d = idx_inc;
            end
         end else if ((idx_q != '0) && first_sym) begin
            // Restart only against pat[0]; no deeper overlap search.
            if (len_q == IDX_ONE) begin
               idx_d   = '0;
               match_d = 1'b1;
            end else begin
               idx_d = IDX_ONE;
            end
         end else begin
            idx_d = '0;
         end
      end else if (idle_step) begin
         if (gap_q == GAP_LAST) begin
            idx_d     = '0;
            gap_d     = '0;
            timeout_d = 1'b1;
         end else begin
            gap_d = gap_q + GAPW'(1);
         end
      end
   end

   // Saturating match counter; a clear beats a coincident match.
   always_comb begin
      count_d = count_q;
      if (bus.cnt_clr)                       count_d = '0;
      else if (match_d && (count_q != '1))   count_d = count_q + CNT_W'(1);
   end

   // State registers with synchronous reset; reset also wipes the programmed pattern.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
         len_q     <= LEN_MAX;
         idx_q     <= '0;
         gap_q     <= '0;
         match_q   <= 1'b0;
         timeout_q <= 1'b0;
         count_q   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) pat_q[i] <= pat_d[i];
         len_q     <= len_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         match_q   <= match_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
      end
   end

   assign bus.first_hit   = (idx_q == '0) & bus.en & bus.in_valid & first_sym;
   assign bus.armed       = (idx_q != '0);
   assign bus.progress    = idx_q;
   assign bus.match       = match_q;
   assign bus.timeout     = timeout_q;
   assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: three instances share one stimulus stream
// (gap limit 3, no gap limit, 2-bit counter) and registered results are queued
// when stimulus is driven and compared after the following clock edge.
module tb_seq_detect_param;

   localparam int WIDTH = 2;
   localparam int DEPTH = 4;

   localparam int S_MATCH_A = 0;
   localparam int S_PROG_A  = 1;
   localparam int S_CNT_A   = 2;
   localparam int S_TO_A    = 3;
   localparam int S_ARMED_A = 4;
   localparam int S_PROG_B  = 5;
   localparam int S_TO_B    = 6;
   localparam int S_CNT_C   = 7;
   localparam int S_MATCH_C = 8;

   typedef struct {
      string tag;
      int    sel;
      int    val;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   seq_detect_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) bus_a ();
   seq_detect_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) bus_b ();
   seq_detect_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) bus_c ();

   assign bus_b.en         = bus_a.en;
   assign bus_b.in_valid   = bus_a.in_valid;
   assign bus_b.in_sym     = bus_a.in_sym;
   assign bus_b.cfg_we     = bus_a.cfg_we;
   assign bus_b.cfg_idx    = bus_a.cfg_idx;
   assign bus_b.cfg_sym    = bus_a.cfg_sym;
   assign bus_b.cfg_len_we = bus_a.cfg_len_we;
   assign bus_b.cfg_len    = bus_a.cfg_len;
   assign bus_b.cnt_clr    = bus_a.cnt_clr;
   assign bus_c.en         = bus_a.en;
   assign bus_c.in_valid   = bus_a.in_valid;
   assign bus_c.in_sym     = bus_a.in_sym;
   assign bus_c.cfg_we     = bus_a.cfg_we;
   assign bus_c.cfg_idx    = bus_a.cfg_idx;
   assign bus_c.cfg_sym    = bus_a.cfg_sym;
   assign bus_c.cfg_len_we = bus_a.cfg_len_we;
   assign bus_c.cfg_len    = bus_a.cfg_len;
   assign bus_c.cnt_clr    = bus_a.cnt_clr;

   seq_detect_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8), .MAX_GAP(3)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a.slave));
   seq_detect_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8), .MAX_GAP(0)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b.slave));
   seq_detect_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2), .MAX_GAP(3)) dut_c (
      .clk (clk), .rst (rst), .bus (bus_c.slave));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_MATCH_A: return 32'(bus_a.match);
         S_PROG_A:  return 32'(bus_a.progress);
         S_CNT_A:   return 32'(bus_a.match_count);
         S_TO_A:    return 32'(bus_a.timeout);
         S_ARMED_A: return 32'(bus_a.armed);
         S_PROG_B:  return 32'(bus_b.progress);
         S_TO_B:    return 32'(bus_b.timeout);
         S_CNT_C:   return 32'(bus_c.match_count);
         S_MATCH_C: return 32'(bus_c.match);
         default:   return 'x;
      endcase
   endfunction

   task automatic push_exp(input string tag, input int sel, input int val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.tag, observe(e.sel), 32'(e.val));
      end
   endtask

   task automatic fh_chk(input string tag, input int exp);
      #1;
      chk(tag, 32'(bus_a.first_hit), 32'(exp));
   endtask

   task automatic drive_sym(input int s);
      bus_a.in_valid   = 1'b1;
      bus_a.in_sym     = 2'(s);
      bus_a.cfg_we     = 1'b0;
      bus_a.cfg_len_we = 1'b0;
      bus_a.cnt_clr    = 1'b0;
   endtask

   task automatic drive_idle();
      bus_a.in_valid   = 1'b0;
      bus_a.in_sym     = '0;
      bus_a.cfg_we     = 1'b0;
      bus_a.cfg_len_we = 1'b0;
      bus_a.cnt_clr    = 1'b0;
   endtask

   task automatic write_slot(input int i, input int s);
      drive_idle();
      bus_a.cfg_we  = 1'b1;
      bus_a.cfg_idx = 3'(i);
      bus_a.cfg_sym = 2'(s);
      push_exp("cfg_slot_abort", S_PROG_A, 0);
      step();
      bus_a.cfg_we = 1'b0;
   endtask

   task automatic write_len(input int l);
      drive_idle();
      bus_a.cfg_len_we = 1'b1;
      bus_a.cfg_len    = 3'(l);
      push_exp("cfg_len_abort", S_PROG_A, 0);
      step();
      bus_a.cfg_len_we = 1'b0;
   endtask

   task automatic feed(input int s, input int prog);
      drive_sym(s);
      push_exp("feed_prog", S_PROG_A, prog);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst              = 1'b1;
      bus_a.en         = 1'b0;
      bus_a.in_valid   = 1'b0;
      bus_a.in_sym     = '0;
      bus_a.cfg_we     = 1'b0;
      bus_a.cfg_idx    = '0;
      bus_a.cfg_sym    = '0;
      bus_a.cfg_len_we = 1'b0;
      bus_a.cfg_len    = '0;
      bus_a.cnt_clr    = 1'b0;
      step();
      push_exp("rst_prog", S_PROG_A, 0);
      push_exp("rst_armed", S_ARMED_A, 0);
      push_exp("rst_match", S_MATCH_A, 0);
      push_exp("rst_timeout", S_TO_A, 0);
      push_exp("rst_count", S_CNT_A, 0);
      push_exp("rst_count_c", S_CNT_C, 0);
      step();
      rst      = 1'b0;
      bus_a.en = 1'b1;

      // full 4-symbol match
      write_slot(0, 1); write_slot(1, 2); write_slot(2, 3); write_slot(3, 0);
      write_len(4);
      drive_sym(1);
      fh_chk("t1_first_hit", 1);
      push_exp("t1_prog1", S_PROG_A, 1);
      step();
      drive_sym(2);
      fh_chk("t1_first_hit_armed", 0);
      push_exp("t1_prog2", S_PROG_A, 2);
      step();
      drive_sym(3);
      push_exp("t1_prog3", S_PROG_A, 3);
      push_exp("t1_armed", S_ARMED_A, 1);
      step();
      drive_sym(0);
      push_exp("t1_match", S_MATCH_A, 1);
      push_exp("t1_prog_end", S_PROG_A, 0);
      push_exp("t1_count", S_CNT_A, 1);
      push_exp("t1_count_c", S_CNT_C, 1);
      push_exp("t1_match_c", S_MATCH_C, 1);
      step();
      drive_idle();
      push_exp("t1_match_pulse", S_MATCH_A, 0);
      push_exp("t1_count_hold", S_CNT_A, 1);
      step();

      // restart without deep overlap: pat 1,1,2 stream 1,1,1,2
      write_slot(1, 1); write_slot(2, 2); write_len(3);
      feed(1, 1);
      feed(1, 2);
      drive_sym(1);
      push_exp("t2_restart", S_PROG_A, 1);
      push_exp("t2_no_match3", S_MATCH_A, 0);
      step();
      drive_sym(2);
      push_exp("t2_after_sym4", S_PROG_A, 0);
      push_exp("t2_no_match4", S_MATCH_A, 0);
      step();

      // gap timeout at idx 2 (and no timeout with the gap limit disabled)
      feed(1, 1);
      drive_sym(1);
      push_exp("t3_armed_b", S_PROG_B, 2);
      push_exp("t3_armed_a", S_PROG_A, 2);
      step();
      drive_idle();
      push_exp("t3_gap1", S_PROG_A, 2);
      push_exp("t3_gap1_to", S_TO_A, 0);
      step();
      push_exp("t3_gap2", S_PROG_A, 2);
      push_exp("t3_gap2_to", S_TO_A, 0);
      step();
      push_exp("t3_timeout", S_TO_A, 1);
      push_exp("t3_to_prog", S_PROG_A, 0);
      push_exp("t3_to_armed", S_ARMED_A, 0);
      push_exp("t3_b_no_to", S_TO_B, 0);
      step();
      push_exp("t3_to_pulse", S_TO_A, 0);
      step();
      for (int k = 0; k < 5; k++) begin
         push_exp("t3_b_hold", S_PROG_B, 2);
         step();
      end

      // symbol on the limit cycle takes priority over the timeout
      push_exp("t3_cfg_abort_b", S_PROG_B, 0);
      write_len(3);
      feed(1, 1);
      feed(1, 2);
      drive_idle();
      step();
      step();
      drive_sym(1);
      push_exp("t3_prio_prog", S_PROG_A, 1);
      push_exp("t3_prio_no_to", S_TO_A, 0);
      step();

      // en=0 holds idx and blocks gap counting and first_hit
      bus_a.en = 1'b0;
      drive_idle();
      for (int k = 0; k < 4; k++) begin
         push_exp("en0_hold", S_PROG_A, 1);
         push_exp("en0_no_to", S_TO_A, 0);
         step();
      end
      drive_sym(1);
      fh_chk("en0_first_hit", 0);
      push_exp("en0_sym_ignored", S_PROG_A, 1);
      step();
      bus_a.en = 1'b1;

      // length 1 (written as 0), back-to-back matches and counter saturation
      drive_idle();
      bus_a.cnt_clr = 1'b1;
      push_exp("t4_clr", S_CNT_A, 0);
      push_exp("t4_clr_c", S_CNT_C, 0);
      step();
      write_slot(0, 3);
      write_len(0);
      for (int k = 1; k <= 5; k++) begin
         drive_sym(3);
         push_exp("t4_match", S_MATCH_A, 1);
         push_exp("t4_count", S_CNT_A, k);
         push_exp("t4_match_c", S_MATCH_C, 1);
         push_exp("t4_count_sat", S_CNT_C, (k > 3) ? 3 : k);
         step();
      end
      drive_sym(2);
      push_exp("t4_miss", S_MATCH_A, 0);
      push_exp("t4_count_hold", S_CNT_A, 5);
      step();

      // config write on the final symbol, clear vs match, length clamp
      write_slot(0, 1); write_slot(1, 2); write_slot(2, 3); write_slot(3, 0);
      write_len(7);
      feed(1, 1); feed(2, 2); feed(3, 3);
      drive_sym(0);
      bus_a.cfg_we  = 1'b1;
      bus_a.cfg_idx = 3'd3;
      bus_a.cfg_sym = 2'd0;
      bus_a.cnt_clr = 1'b1;
      push_exp("t5_cfg_abort", S_PROG_A, 0);
      push_exp("t5_cfg_no_match", S_MATCH_A, 0);
      push_exp("t5_cfg_clr", S_CNT_A, 0);
      step();
      feed(1, 1); feed(2, 2); feed(3, 3);
      drive_sym(0);
      bus_a.cnt_clr = 1'b1;
      push_exp("t5_clr_match", S_MATCH_A, 1);
      push_exp("t5_clr_wins", S_CNT_A, 0);
      step();
      write_slot(5, 2);
      feed(1, 1); feed(2, 2); feed(3, 3);
      drive_sym(0);
      push_exp("t5_clamp_match", S_MATCH_A, 1);
      push_exp("t5_clamp_count", S_CNT_A, 1);
      step();

      // reset mid-sequence wipes pattern and length
      feed(1, 1);
      drive_sym(2);
      push_exp("t6_armed", S_ARMED_A, 1);
      step();
      rst = 1'b1;
      drive_sym(3);
      push_exp("t6_rst_prog", S_PROG_A, 0);
      push_exp("t6_rst_armed", S_ARMED_A, 0);
      push_exp("t6_rst_count", S_CNT_A, 0);
      step();
      rst = 1'b0;
      drive_sym(1);
      fh_chk("t6_fh_sym1", 0);
      push_exp("t6_sym1", S_PROG_A, 0);
      step();
      drive_sym(0);
      fh_chk("t6_fh_sym0", 1);
      push_exp("t6_p1", S_PROG_A, 1);
      step();
      feed(0, 2);
      feed(0, 3);
      drive_sym(0);
      push_exp("t6_len4_match", S_MATCH_A, 1);
      push_exp("t6_len4_count", S_CNT_A, 1);
      step();
      drive_idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
